fetch_stage_ctrl: RTL and testbench

- Consumes the `stall`/`flush` pair from the hazard unit and acts on it.
- Owns the PC register, the instruction-memory fetch address and the IF/ID pipeline register.
- Inserts NOP bubbles on flush and holds state on stall.
- Keeps hazard performance counters so stall and flush rates are visible to software and to benches.

---
 rtl/fetch_stage_ctrl.sv | 88 ++++++++
 tb/tb_fetch_stage_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register, imem address and IF/ID register; flush beats stall beats advance.
// imem_addr is the combinational next PC; IF/ID updates one edge later; stall freezes everything.
module fetch_stage_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  pc_IF,
  output logic [XLEN-1:0]  pc_ID,
  output logic [31:0]      instr_ID,
  output logic             valid_ID,
  output logic [CNT_W-1:0] cnt_cycles,
  output logic [CNT_W-1:0] cnt_issued,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, SQUASH} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            load_id;
  logic [31:0]     id_instr_nxt;
  logic            id_valid_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt    = RUN;
    pc_nxt       = pc_IF + XLEN'(4);
    load_id      = 1'b1;
    id_instr_nxt = imem_rdata;
    id_valid_nxt = 1'b1;
    // imem_rdata is not yet meaningful in the first cycle after reset
    if (state == BOOT) begin
      id_instr_nxt = NOP_INSTR;
      id_valid_nxt = 1'b0;
    end
    if (flush) begin
      state_nxt    = SQUASH;
      pc_nxt       = {branch_target[XLEN-1:2], 2'b00};
      id_instr_nxt = NOP_INSTR;
      id_valid_nxt = 1'b0;
    end else if (stall) begin
      state_nxt = HOLD;
      pc_nxt    = pc_IF;
      load_id   = 1'b0;
    end
    imem_addr = reset ? RESET_PC : pc_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      pc_IF      <= RESET_PC;
      pc_ID      <= '0;
      instr_ID   <= NOP_INSTR;
      valid_ID   <= 1'b0;
      cnt_cycles <= '0;
      cnt_issued <= '0;
      cnt_stall  <= '0;
      cnt_flush  <= '0;
    end else begin
      state      <= state_nxt;
      pc_IF      <= pc_nxt;
      cnt_cycles <= sat_inc(cnt_cycles);
      if (load_id) begin
        pc_ID    <= pc_IF;
        instr_ID <= id_instr_nxt;
        valid_ID <= id_valid_nxt;
      end
      if (load_id && id_valid_nxt) cnt_issued <= sat_inc(cnt_issued);
      if (stall && !flush)         cnt_stall  <= sat_inc(cnt_stall);
      if (flush)                   cnt_flush  <= sat_inc(cnt_flush);
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed table of per-cycle hazard inputs with hand-computed fetch state, plus reset and saturation sequences.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, pc_IF, pc_ID, instr_ID;
  logic        valid_ID;
  logic [31:0] cnt_cycles, cnt_issued, cnt_stall, cnt_flush;

  logic [31:0] s_addr, s_pc_if, s_pc_id, s_instr;
  logic        s_valid;
  logic [3:0]  s_cycles, s_issued, s_stall, s_flush;
  logic [31:0] s_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Synchronous imem: data at address a is ~a
  always_ff @(posedge clk) imem_rdata <= ~imem_addr;

  fetch_stage_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_target(branch_target), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pc_IF(pc_IF), .pc_ID(pc_ID),
    .instr_ID(instr_ID), .valid_ID(valid_ID),
    .cnt_cycles(cnt_cycles), .cnt_issued(cnt_issued),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  fetch_stage_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_target(branch_target), .imem_rdata(s_rdata),
    .imem_addr(s_addr), .pc_IF(s_pc_if), .pc_ID(s_pc_id),
    .instr_ID(s_instr), .valid_ID(s_valid),
    .cnt_cycles(s_cycles), .cnt_issued(s_issued),
    .cnt_stall(s_stall), .cnt_flush(s_flush)
  );

  typedef struct {
    logic        st;
    logic        fl;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] e_pc_if;
    logic [31:0] e_pc_id;
    logic [31:0] e_instr;
    logic        e_valid;
    int          e_issued;
    int          e_stall;
    int          e_flush;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic [31:0] tgt,
                              input logic [31:0] addr, input logic [31:0] pif,
                              input logic [31:0] pid, input logic [31:0] ins,
                              input logic v, input int iss, input int stl, input int fls);
    vec_t r;
    r.st = st; r.fl = fl; r.tgt = tgt; r.e_addr = addr; r.e_pc_if = pif;
    r.e_pc_id = pid; r.e_instr = ins; r.e_valid = v;
    r.e_issued = iss; r.e_stall = stl; r.e_flush = fls;
    return r;
  endfunction

  initial begin
    //               st fl tgt            addr           pc_IF          pc_ID          instr          v  iss stl fl
    tbl[0]  = mk(0, 0, 32'h0,          32'h4,         32'h4,         32'h0,         NOP,           0, 0,  0,  0);
    tbl[1]  = mk(0, 0, 32'h0,          32'h8,         32'h8,         32'h4,         ~32'h4,        1, 1,  0,  0);
    tbl[2]  = mk(0, 0, 32'h0,          32'hC,         32'hC,         32'h8,         ~32'h8,        1, 2,  0,  0);
    tbl[3]  = mk(0, 0, 32'h0,          32'h10,        32'h10,        32'hC,         ~32'hC,        1, 3,  0,  0);
    tbl[4]  = mk(1, 0, 32'h0,          32'h10,        32'h10,        32'hC,         ~32'hC,        1, 3,  1,  0);
    tbl[5]  = mk(1, 0, 32'h0,          32'h10,        32'h10,        32'hC,         ~32'hC,        1, 3,  2,  0);
    tbl[6]  = mk(1, 0, 32'h0,          32'h10,        32'h10,        32'hC,         ~32'hC,        1, 3,  3,  0);
    tbl[7]  = mk(0, 0, 32'h0,          32'h14,        32'h14,        32'h10,        ~32'h10,       1, 4,  3,  0);
    tbl[8]  = mk(1, 1, 32'h103,        32'h100,       32'h100,       32'h14,        NOP,           0, 4,  3,  1);
    tbl[9]  = mk(0, 0, 32'h0,          32'h104,       32'h104,       32'h100,       ~32'h100,      1, 5,  3,  1);
    tbl[10] = mk(0, 1, 32'h40,         32'h40,        32'h40,        32'h104,       NOP,           0, 5,  3,  2);
    tbl[11] = mk(0, 1, 32'h80,         32'h80,        32'h80,        32'h40,        NOP,           0, 5,  3,  3);
    tbl[12] = mk(0, 0, 32'h0,          32'h84,        32'h84,        32'h80,        ~32'h80,       1, 6,  3,  3);
    tbl[13] = mk(0, 1, 32'hFFFF_FFFE,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h84,        NOP,           0, 6,  3,  4);
    tbl[14] = mk(0, 0, 32'h0,          32'h0,         32'h0,         32'hFFFF_FFFC, 32'h3,         1, 7,  3,  4);
    tbl[15] = mk(0, 0, 32'h0,          32'h4,         32'h4,         32'h0,         32'hFFFF_FFFF, 1, 8,  3,  4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst pc_IF", pc_IF, 32'h0);
    chk("rst pc_ID", pc_ID, 32'h0);
    chk("rst instr_ID", instr_ID, NOP);
    chk("rst valid_ID", {31'b0, valid_ID}, 32'h0);
    chk("rst cnt_cycles", cnt_cycles, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].st;
      flush = tbl[i].fl;
      branch_target = tbl[i].tgt;
      #1;
      chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc_IF", i), pc_IF, tbl[i].e_pc_if);
      chk($sformatf("v%0d pc_ID", i), pc_ID, tbl[i].e_pc_id);
      chk($sformatf("v%0d instr_ID", i), instr_ID, tbl[i].e_instr);
      chk($sformatf("v%0d valid_ID", i), {31'b0, valid_ID}, {31'b0, tbl[i].e_valid});
      chk($sformatf("v%0d cnt_cycles", i), cnt_cycles, 32'(i + 1));
      chk($sformatf("v%0d cnt_issued", i), cnt_issued, 32'(tbl[i].e_issued));
      chk($sformatf("v%0d cnt_stall", i), cnt_stall, 32'(tbl[i].e_stall));
      chk($sformatf("v%0d cnt_flush", i), cnt_flush, 32'(tbl[i].e_flush));
      @(negedge clk);
    end
    stall = 1'b0;
    flush = 1'b0;

    // Narrow counters: 16 cycles have elapsed, so cycles must sit at 4'hF
    chk("sat cycles@16", {28'b0, s_cycles}, 32'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat cycles@19", {28'b0, s_cycles}, 32'hF);
    chk("sat issued", {28'b0, s_issued}, 32'd11);

    // Async reset pulse between edges while holding
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk);
    #1;
    chk("hold cnt_stall", cnt_stall, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("arst pc_IF", pc_IF, 32'h0);
    chk("arst pc_ID", pc_ID, 32'h0);
    chk("arst instr_ID", instr_ID, NOP);
    chk("arst valid_ID", {31'b0, valid_ID}, 32'h0);
    chk("arst imem_addr", imem_addr, 32'h0);
    chk("arst cnt_cycles", cnt_cycles, 32'h0);
    chk("arst cnt_stall", cnt_stall, 32'h0);
    chk("arst cnt_issued", cnt_issued, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    chk("boot2 imem_addr", imem_addr, 32'h4);
    @(posedge clk);
    #1;
    chk("boot2 pc_IF", pc_IF, 32'h4);
    chk("boot2 valid_ID", {31'b0, valid_ID}, 32'h0);
    chk("boot2 cnt_cycles", cnt_cycles, 32'h1);
    @(posedge clk);
    #1;
    chk("boot2 pc_ID", pc_ID, 32'h4);
    chk("boot2 instr_ID", instr_ID, ~32'h4);
    chk("boot2 valid1", {31'b0, valid_ID}, 32'h1);
    chk("boot2 cnt_issued", cnt_issued, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
